// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 keyboard front end for the two-player game.
// Oversamples the raw PS/2 clock/data on clk, synchronises and filters them,
// deframes 11-bit frames, follows E0/F0 prefixes and keeps a held-key bitmap
// per player.
// Optional build macro: PS2_PARITY_CHECK_EN enables odd-parity checking and
// the parity_err pulse; without it the parity bit is captured but ignored.
module ps2_key_decoder #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic [4:0] p1_keys,
  output logic [4:0] p2_keys
);

  localparam int unsigned FCNT_W = $clog2(FILTER_LEN + 1);
  localparam int unsigned WD_W   = $clog2(TIMEOUT_CYCLES + 1);

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   w_clk_s;
  logic                   w_data_s;
  logic [FCNT_W-1:0]      r_clk_cnt;
  logic [FCNT_W-1:0]      r_data_cnt;
  logic                   r_clk_filt;
  logic                   r_data_filt;
  logic                   r_fall;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [7:0]             r_shift;
  logic [2:0]             r_bit_idx;
  logic                   r_parity;
  logic [WD_W-1:0]        r_wd;
  logic                   w_timeout;
  logic                   w_par_ok;
  logic                   w_accept;
  logic                   w_perr;
  logic                   w_ferr;

  logic                   r_ext;
  logic                   r_brk;
  logic [4:0]             w_p1_mask;
  logic [4:0]             w_p2_mask;

  assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
  assign w_data_s = r_data_sync[SYNC_STAGES-1];

  // Synchronisers for the asynchronous keyboard lines, idle-high after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  // Clock-line filter: change only after FILTER_LEN differing samples; strobe on falling edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_filt <= 1'b1;
      r_clk_cnt  <= '0;
      r_fall     <= 1'b0;
    end else begin
      r_fall <= 1'b0;
      if (w_clk_s == r_clk_filt) begin
        r_clk_cnt <= '0;
      end else if (r_clk_cnt == FCNT_W'(FILTER_LEN - 1)) begin
        r_clk_filt <= w_clk_s;
        r_clk_cnt  <= '0;
        r_fall     <= ~w_clk_s;
      end else begin
        r_clk_cnt <= r_clk_cnt + FCNT_W'(1);
      end
    end
  end

  // Data-line filter, same saturating scheme as the clock line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_filt <= 1'b1;
      r_data_cnt  <= '0;
    end else if (w_data_s == r_data_filt) begin
      r_data_cnt <= '0;
    end else if (r_data_cnt == FCNT_W'(FILTER_LEN - 1)) begin
      r_data_filt <= w_data_s;
      r_data_cnt  <= '0;
    end else begin
      r_data_cnt <= r_data_cnt + FCNT_W'(1);
    end
  end

  // Mid-frame watchdog expiry: r_wd holds cycles elapsed since the last fall
  assign w_timeout = (r_state != S_IDLE) && !r_fall &&
                     (r_wd == WD_W'(TIMEOUT_CYCLES - 1));

  // Odd parity across the eight data bits plus the parity bit
  assign w_par_ok = ^{r_parity, r_shift};

  // Frame FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Frame FSM next state: advance only on the filtered falling edge
  always_comb begin
    w_state_nxt = r_state;
    if (w_timeout) begin
      w_state_nxt = S_IDLE;
    end else if (r_fall) begin
      case (r_state)
        S_IDLE:   if (!r_data_filt) w_state_nxt = S_DATA;
        S_DATA:   if (r_bit_idx == 3'd7) w_state_nxt = S_PARITY;
        S_PARITY: w_state_nxt = S_STOP;
        S_STOP:   w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Frame FSM outputs: stop-bit verdict and timeout error
  always_comb begin
    w_accept = 1'b0;
    w_perr   = 1'b0;
    w_ferr   = w_timeout;
    if (r_fall && (r_state == S_STOP)) begin
      if (!r_data_filt) begin
        w_ferr = 1'b1;
      end else if (w_par_ok || !PARITY_EN) begin
        w_accept = 1'b1;
      end else begin
        w_perr = 1'b1;
      end
    end
  end

  // Frame datapath: LSB-first shifter, bit index, parity capture, watchdog
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_parity  <= 1'b0;
      r_wd      <= '0;
    end else if (r_fall) begin
      r_wd <= WD_W'(1);
      case (r_state)
        S_IDLE: r_bit_idx <= '0;
        S_DATA: begin
          r_shift   <= {r_data_filt, r_shift[7:1]};
          r_bit_idx <= r_bit_idx + 3'd1;
        end
        S_PARITY: r_parity <= r_data_filt;
        default: ;
      endcase
    end else if ((r_state == S_IDLE) || w_timeout) begin
      r_wd <= '0;
    end else begin
      r_wd <= r_wd + WD_W'(1);
    end
  end

  // Registered frame results, one cycle after the deciding edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_code  <= '0;
      scan_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      scan_valid <= w_accept;
      parity_err <= w_perr;
      frame_err  <= w_ferr;
      if (w_accept) begin
        scan_code <= r_shift;
      end
    end
  end

  // Key map lookup; keypad codes without the E0 prefix stay unmapped
  always_comb begin
    w_p1_mask = '0;
    w_p2_mask = '0;
    if (r_ext) begin
      case (scan_code)
        8'h75:   w_p1_mask = 5'b00001;
        8'h6B:   w_p1_mask = 5'b00010;
        8'h74:   w_p1_mask = 5'b00100;
        8'h72:   w_p1_mask = 5'b01000;
        default: ;
      endcase
    end else begin
      case (scan_code)
        8'h29:   w_p1_mask = 5'b10000;
        8'h1D:   w_p2_mask = 5'b00001;
        8'h1C:   w_p2_mask = 5'b00010;
        8'h23:   w_p2_mask = 5'b00100;
        8'h1B:   w_p2_mask = 5'b01000;
        8'h0D:   w_p2_mask = 5'b10000;
        default: ;
      endcase
    end
  end

  // Code decoder: prefix flags, press/release and keyboard error recovery
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ext   <= 1'b0;
      r_brk   <= 1'b0;
      p1_keys <= '0;
      p2_keys <= '0;
    end else if (scan_valid) begin
      if (scan_code == 8'hE0) begin
        r_ext <= 1'b1;
      end else if (scan_code == 8'hF0) begin
        r_brk <= 1'b1;
      end else if ((scan_code == 8'h00) || (scan_code == 8'hFF)) begin
        r_ext   <= 1'b0;
        r_brk   <= 1'b0;
        p1_keys <= '0;
        p2_keys <= '0;
      end else begin
        r_ext   <= 1'b0;
        r_brk   <= 1'b0;
        p1_keys <= r_brk ? (p1_keys & ~w_p1_mask) : (p1_keys | w_p1_mask);
        p2_keys <= r_brk ? (p2_keys & ~w_p2_mask) : (p2_keys | w_p2_mask);
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: drives PS/2 frames bit by bit and
// checks decoded codes, error pulses, latency and the per-player key bitmaps.
// Expectations follow the build macro PS2_PARITY_CHECK_EN.
`timescale 1ns/1ps
module tb_ps2_key_decoder;

  localparam int unsigned SYNC_STAGES    = 2;
  localparam int unsigned FILTER_LEN     = 8;
  localparam int unsigned TIMEOUT_CYCLES = 200;
  localparam int unsigned HALF_BIT       = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       parity_err;
  logic       frame_err;
  logic [4:0] p1_keys;
  logic [4:0] p2_keys;

  int unsigned n_vec = 0;
  int unsigned n_miss = 0;
  int unsigned cyc = 0;
  int unsigned last_fall_cyc = 0;

  int unsigned n_sv = 0;
  int unsigned n_pe = 0;
  int unsigned n_fe = 0;
  int unsigned fe_cyc = 0;
  logic [7:0] last_code = '0;
  logic [9:0] keys_at_sv = '0;
  logic [9:0] keys_post = '0;
  logic       sv_prev = 1'b0;
  int unsigned sv0, pe0, fe0;

  ps2_key_decoder #(
    .SYNC_STAGES   (SYNC_STAGES),
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .scan_code (scan_code),
    .scan_valid(scan_valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .p1_keys   (p1_keys),
    .p2_keys   (p2_keys)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor sampled on the falling system-clock edge
  always @(negedge clk) begin
    sv_prev <= scan_valid;
    if (sv_prev) keys_post <= {p1_keys, p2_keys};
    if (scan_valid) begin
      n_sv       <= n_sv + 1;
      last_code  <= scan_code;
      keys_at_sv <= {p1_keys, p2_keys};
    end
    if (parity_err) n_pe <= n_pe + 1;
    if (frame_err) begin
      n_fe   <= n_fe + 1;
      fe_cyc <= cyc;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    sv0 = n_sv;
    pe0 = n_pe;
    fe0 = n_fe;
  endtask

  task automatic check_counts(input string tag, input int unsigned dsv,
                              input int unsigned dpe, input int unsigned dfe);
    check_val({tag, "_valid"}, 32'(n_sv - sv0), 32'(dsv));
    check_val({tag, "_perr"},  32'(n_pe - pe0), 32'(dpe));
    check_val({tag, "_ferr"},  32'(n_fe - fe0), 32'(dfe));
  endtask

  // One PS/2 bit: data set while clock high, then a low and a high half period
  task automatic send_bit(input logic b, input bit glitch);
    ps2_data = b;
    if (glitch) begin
      wait_cyc(6);
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      wait_cyc(HALF_BIT - 9);
    end else begin
      wait_cyc(HALF_BIT);
    end
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    wait_cyc(HALF_BIT);
    ps2_clk = 1'b1;
  endtask

  // Full 11-bit frame; glitch_bit selects a bit slot (0 = start) to glitch
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                            input int glitch_bit);
    send_bit(1'b0, glitch_bit == 0);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch_bit == i + 1);
    send_bit(par, 1'b0);
    send_bit(stp, 1'b0);
    ps2_data = 1'b1;
    wait_cyc(HALF_BIT);
  endtask

  task automatic send_key(input logic [7:0] b);
    send_frame(b, ~^b, 1'b1, -1);
  endtask

  initial begin
    rst_n = 1'b0;
    wait_cyc(5);
    check_val("rst_code",  32'(scan_code),  32'h0);
    check_val("rst_valid", 32'(scan_valid), 32'h0);
    check_val("rst_perr",  32'(parity_err), 32'h0);
    check_val("rst_ferr",  32'(frame_err),  32'h0);
    check_val("rst_p1",    32'(p1_keys),    32'h0);
    check_val("rst_p2",    32'(p2_keys),    32'h0);
    rst_n = 1'b1;
    wait_cyc(5);

    // Press 'w' (1D) with latency check
    snap();
    send_frame(8'h1D, 1'b1, 1'b1, -1);
    check_counts("w_press", 1, 0, 0);
    check_val("w_code", 32'(last_code), 32'h1D);
    check_val("w_keys_at_valid", 32'(keys_at_sv), 32'h000);
    check_val("w_keys_next", 32'(keys_post), 32'h001);
    send_key(8'hF0);
    send_key(8'h1D);
    check_val("w_release_p2", 32'(p2_keys), 32'h00);

    // Simultaneous press then release
    send_frame(8'h29, 1'b0, 1'b1, -1);
    check_val("shoot_p1", 32'(p1_keys), 32'b10000);
    send_frame(8'hE0, 1'b0, 1'b1, -1);
    send_frame(8'h75, 1'b0, 1'b1, -1);
    check_val("up_p1", 32'(p1_keys), 32'b10001);
    send_frame(8'hF0, 1'b1, 1'b1, -1);
    send_frame(8'h29, 1'b0, 1'b1, -1);
    check_val("shoot_rel_p1", 32'(p1_keys), 32'b00001);
    check_val("sim_p2", 32'(p2_keys), 32'h00);

    // Parity fault
    snap();
    send_frame(8'h1D, 1'b0, 1'b1, -1);
`ifdef PS2_PARITY_CHECK_EN
    check_counts("par_bad", 0, 1, 0);
    check_val("par_bad_p2", 32'(p2_keys), 32'h00);
`else
    check_counts("par_ign", 1, 0, 0);
    check_val("par_ign_p2", 32'(p2_keys), 32'b00001);
`endif
    send_key(8'hF0);
    send_key(8'h1D);
    check_val("par_clean_p2", 32'(p2_keys), 32'h00);

    // Bad stop bit
    snap();
    send_frame(8'h29, 1'b0, 1'b0, -1);
    check_counts("bad_stop", 0, 0, 1);
    check_val("bad_stop_p1", 32'(p1_keys), 32'b00001);

    // Short clock glitch inside a frame is ignored
    snap();
    send_frame(8'h1D, 1'b1, 1'b1, 3);
    check_counts("glitch", 1, 0, 0);
    check_val("glitch_code", 32'(last_code), 32'h1D);
    check_val("glitch_p2", 32'(p2_keys), 32'b00001);

    // Timeout after four bits
    snap();
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    for (int k = 0; k < int'(TIMEOUT_CYCLES) + 100 && n_fe == fe0; k++) @(negedge clk);
    wait_cyc(20);
    check_counts("timeout", 0, 0, 1);
    check_val("timeout_delay", 32'(fe_cyc - last_fall_cyc),
              32'(SYNC_STAGES + FILTER_LEN + TIMEOUT_CYCLES));
    check_val("timeout_p1", 32'(p1_keys), 32'b00001);
    check_val("timeout_p2", 32'(p2_keys), 32'b00001);
    snap();
    send_key(8'h1D);
    check_counts("post_to", 1, 0, 0);
    check_val("post_to_code", 32'(last_code), 32'h1D);
    check_val("typematic_p2", 32'(p2_keys), 32'b00001);

    // Keyboard error code clears everything, including a pending E0
    send_key(8'hFF);
    check_val("ff_p1", 32'(p1_keys), 32'h00);
    check_val("ff_p2", 32'(p2_keys), 32'h00);
    send_key(8'hE0);
    send_key(8'h00);
    send_key(8'h75);
    check_val("err_clr_ext_p1", 32'(p1_keys), 32'h00);

    // Remaining key map entries and an extended release
    send_key(8'hE0); send_key(8'h6B);
    check_val("left_p1", 32'(p1_keys), 32'b00010);
    send_key(8'h23);
    send_key(8'h1C);
    check_val("d_a_p2", 32'(p2_keys), 32'b00110);
    send_key(8'hE0); send_key(8'hF0); send_key(8'h6B);
    check_val("left_rel_p1", 32'(p1_keys), 32'h00);
    send_key(8'hF0); send_key(8'h23);
    send_key(8'h0D);
    send_key(8'h1B);
    check_val("tab_s_p2", 32'(p2_keys), 32'b11010);
    send_key(8'hE0); send_key(8'h74);
    send_key(8'hE0); send_key(8'h72);
    check_val("right_down_p1", 32'(p1_keys), 32'b01100);

    // Asynchronous reset in the middle of a frame
    send_key(8'hE0); send_key(8'h75);
    check_val("pre_rst_p1", 32'(p1_keys), 32'b01101);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    ps2_data = 1'b0;
    wait_cyc(5);
    ps2_clk = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_code",  32'(scan_code),  32'h0);
    check_val("arst_valid", 32'(scan_valid), 32'h0);
    check_val("arst_perr",  32'(parity_err), 32'h0);
    check_val("arst_ferr",  32'(frame_err),  32'h0);
    check_val("arst_p1",    32'(p1_keys),    32'h0);
    check_val("arst_p2",    32'(p2_keys),    32'h0);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(5);
    rst_n = 1'b1;
    wait_cyc(5);
    snap();
    send_key(8'h75);
    check_counts("keypad", 1, 0, 0);
    check_val("keypad_code", 32'(last_code), 32'h75);
    check_val("keypad_p1", 32'(p1_keys), 32'h00);
    check_val("keypad_p2", 32'(p2_keys), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
